sr_command_driver: RTL
======================

# sr_command_driver

Clocked driver for the S/R inputs of the asynchronous-reset SR latch (`srgate`). It accepts two raw, bouncy, asynchronous push-button inputs and brings each into the `CLK` domain through a synchronizer and a debouncer. It converts each debounced press into a fixed-length, mutually exclusive pulse on `S` or `R`, so the latch never sees {S,R}=11 and never sees glitches. It sits between the board buttons and the latch, and it also reports the last commanded latch state.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops per input. Legal values are 2 or more.
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a synchronized level must persist before it is accepted. Legal values are 1 or more.
- `PULSE_CYCLES`, default 2: width of each S/R output pulse in clock cycles. Legal values are 1 or more.
- `CLK`  input  1: single clock. All state changes happen on the rising edge.
- `nReset`  input  1: asynchronous, active-low reset.
- `BTN_SET`  input  1: raw asynchronous set request (active high, may bounce).
- `BTN_RST`  input  1: raw asynchronous reset request (active high, may bounce).
- `S`  output  1: set pulse to the latch. Registered.
- `R`  output  1: reset pulse to the latch. Registered.
- `BUSY`  output  1: high while a pulse is being driven.
- `LATCHED`  output  1: last commanded state. 1 after an S pulse, 0 after an R pulse.

## Operation
- Reset (`nReset`=0) acts immediately, without waiting for a clock edge:
  - `S`, `R`, `BUSY`, `LATCHED` all go to 0.
  - Synchronizer flops, debounced levels and counters clear to 0.
  - FSM goes to IDLE.
- Each input has its own synchronize-and-debounce path.
  - The debounced level `stable` starts at 0 after reset.
  - The counter increments on each cycle where the synchronized value differs from `stable`.
  - The counter clears to 0 on any cycle where the two are equal.
  - When the counter reaches `DEBOUNCE_CYCLES`, `stable` takes the synchronized value and the counter clears.
- A press event is a 0→1 transition of `stable`, valid for one cycle.
  - Releases (1→0) generate nothing.
  - Holding a button generates exactly one press.
- FSM states:
  - IDLE: `BUSY`=0.
    - Set press only → PULSE_S.
    - Reset press only → PULSE_R.
    - Both in the same cycle → PULSE_R. Reset wins, as the safe state.
  - PULSE_S: `S`=1 for `PULSE_CYCLES` cycles, then `LATCHED`←1 and return to IDLE.
  - PULSE_R: `R`=1 for `PULSE_CYCLES` cycles, then `LATCHED`←0 and return to IDLE.
- A press event occurring while `BUSY`=1 is dropped, not queued.
- Redundant commands are still issued. For example, a set press with `LATCHED`=1 still produces an S pulse.
- Invariants, which must hold on every cycle:
  - `S` and `R` are never both 1.
  - `BUSY` = `S` | `R`.
- Reset asserted mid-pulse:
  - The pulse ends at once and `LATCHED` returns to 0.
  - After release, a button still held is seen as a fresh press once it has been synchronized and debounced.
- Pulse-width counter width is $clog2(`PULSE_CYCLES`+1). Debounce counter width is $clog2(`DEBOUNCE_CYCLES`+1). Neither counter may wrap.

## Timing
- Press latency, counted from the first rising edge that samples the raw input high:
  - Synchronized value is high after edge `SYNC_STAGES`.
  - `stable` rises after edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`.
  - `S`/`R` rises after the following edge.
  - With defaults, the output rises after edge 7.
- Pulse width is exactly `PULSE_CYCLES` cycles.
- `LATCHED` updates on the same edge that deasserts `S`/`R`.
- A new press is accepted in the cycle after `BUSY` falls.
- Bounce rejection: an input high for fewer than `DEBOUNCE_CYCLES` consecutive synchronized cycles produces no press.

## Structure
- Shared package `sr_pkg` holds:
  - the `sr_state_t` enum {IDLE, PULSE_S, PULSE_R};
  - default parameter constants.
- Sub-module `async_debounce` (parameters `SYNC_STAGES`, `DEBOUNCE_CYCLES`):
  - ports `CLK`, `nReset`, `din`, `stable`, `rise`;
  - instantiated twice, once per button.
- The top level contains the FSM, the pulse counter and the `LATCHED` register.

## Test plan
All scenarios use the default parameters.
1. Reset: hold `nReset`=0 while toggling both buttons → `S`=`R`=`BUSY`=`LATCHED`=0 throughout.
2. Clean set: `BTN_SET`=1 held for 20 cycles → `S`=1 after edge 7 for exactly 2 cycles, `LATCHED`=1 at the end, and no second pulse.
3. Bounce: `BTN_SET` pattern 1,1,1,0,1,1,0 (one value per cycle), then 0 → no `S` pulse, `LATCHED` unchanged. Then `BTN_RST` held steady → one 2-cycle `R` pulse, `LATCHED`=0.
4. Simultaneous: `BTN_SET` and `BTN_RST` rise in the same cycle → single `R` pulse only, never {S,R}=11.
5. Busy drop: `BTN_RST` press debounced one cycle after `S` rises → press dropped, `LATCHED`=1.
6. Mid-pulse reset: `nReset` pulled low while `S`=1 → `S` falls before the next edge, `LATCHED`=0. With `BTN_SET` still held, `S` pulses again 7 edges after reset release.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared types and parameter defaults for the SR latch command driver.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE_S = 2'd1,
    PULSE_R = 2'd2
  } sr_state_t;

  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned PULSE_CYCLES_DEF    = 2;

endpackage

// File: rtl/sr_command_driver_if.sv
// Button inputs and latch-side outputs of the SR command driver.
interface sr_command_driver_if;
  logic BTN_SET;
  logic BTN_RST;
  logic S;
  logic R;
  logic BUSY;
  logic LATCHED;

  modport master (
    output BTN_SET, BTN_RST,
    input  S, R, BUSY, LATCHED
  );

  modport slave (
    input  BTN_SET, BTN_RST,
    output S, R, BUSY, LATCHED
  );
endinterface

// File: rtl/async_debounce.sv
// Synchronizer plus level debouncer for one raw asynchronous button.
module async_debounce
  import sr_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic CLK,
  input  logic nReset,
  input  logic din,
  output logic stable,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;
  logic                   sync_c;

  assign sync_c = sync_q[SYNC_STAGES-1];

  // Shift chain, persistence counter and one-cycle press strobe.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], din};
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
    if (sync_c != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync_c;
        rise_d   = sync_c;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;

endmodule

// File: rtl/sr_command_driver.sv
// Turns debounced button presses into exclusive fixed-width S/R pulses.
module sr_command_driver
  import sr_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned PULSE_CYCLES    = PULSE_CYCLES_DEF
) (
  input logic                 CLK,
  input logic                 nReset,
  sr_command_driver_if.slave  bus
);

  localparam int unsigned PCNT_W = $clog2(PULSE_CYCLES + 1);

  logic set_stable, set_rise;
  logic rst_stable, rst_rise;
  logic unused_stable;

  sr_state_t          state_q, state_d;
  logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
  logic               s_q, s_d;
  logic               r_q, r_d;
  logic               busy_q, busy_d;
  logic               latched_q, latched_d;

  async_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db_set (
    .CLK    (CLK),
    .nReset (nReset),
    .din    (bus.BTN_SET),
    .stable (set_stable),
    .rise   (set_rise)
  );

  async_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db_rst (
    .CLK    (CLK),
    .nReset (nReset),
    .din    (bus.BTN_RST),
    .stable (rst_stable),
    .rise   (rst_rise)
  );

  // Debounced levels are only needed as press strobes here.
  assign unused_stable = set_stable ^ rst_stable;

  // Next-state and registered-output logic; reset press wins a tie.
  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    s_d       = s_q;
    r_d       = r_q;
    latched_d = latched_q;
    unique case (state_q)
      IDLE: begin
        pcnt_d = '0;
        s_d    = 1'b0;
        r_d    = 1'b0;
        if (rst_rise) begin
          state_d = PULSE_R;
          r_d     = 1'b1;
          pcnt_d  = PCNT_W'(1);
        end else if (set_rise) begin
          state_d = PULSE_S;
          s_d     = 1'b1;
          pcnt_d  = PCNT_W'(1);
        end
      end
      PULSE_S: begin
        if (pcnt_q == PCNT_W'(PULSE_CYCLES)) begin
          state_d   = IDLE;
          s_d       = 1'b0;
          pcnt_d    = '0;
          latched_d = 1'b1;
        end else begin
          pcnt_d = pcnt_q + PCNT_W'(1);
        end
      end
      PULSE_R: begin
        if (pcnt_q == PCNT_W'(PULSE_CYCLES)) begin
          state_d   = IDLE;
          r_d       = 1'b0;
          pcnt_d    = '0;
          latched_d = 1'b0;
        end else begin
          pcnt_d = pcnt_q + PCNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        s_d     = 1'b0;
        r_d     = 1'b0;
        pcnt_d  = '0;
      end
    endcase
    busy_d = s_d | r_d;
  end

  // FSM and output registers; reset kills any pulse immediately.
  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      state_q   <= IDLE;
      pcnt_q    <= '0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      busy_q    <= 1'b0;
      latched_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      s_q       <= s_d;
      r_q       <= r_d;
      busy_q    <= busy_d;
      latched_q <= latched_d;
    end
  end

  assign bus.S       = s_q;
  assign bus.R       = r_q;
  assign bus.BUSY    = busy_q;
  assign bus.LATCHED = latched_q;

endmodule
